// File: rtl/result_history.sv
// result_history: ring buffer of recent ALU {flags,result} values with a
// browsable view for the hex display and flag LEDs.
// Optional build macro RESULT_HISTORY_DEDUP_EN: when defined, a capture equal
// to the newest stored entry is discarded (the view still snaps to newest).
module result_history #(
    parameter int DEPTH = 8,
    parameter int IDXW  = 3
) (
    input  logic            CLOCK_50,
    input  logic            rst_n,
    input  logic            capture,
    input  logic            clear,
    input  logic [15:0]     result,
    input  logic [4:0]      flags,
    input  logic            live,
    input  logic            step_old,
    input  logic            step_new,
    output logic [15:0]     disp_value,
    output logic [4:0]      disp_flags,
    output logic [IDXW-1:0] view_idx,
    output logic [IDXW:0]   count,
    output logic            empty,
    output logic            full,
    output logic            overflow
);

    localparam int            EW      = 21;
    localparam logic [IDXW:0] DEPTH_C = (IDXW+1)'(DEPTH);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [IDXW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDXW:0]   count_q,  count_d;
    logic [IDXW-1:0] view_q,   view_d;
    logic            ovf_q,    ovf_d;

    logic [EW-1:0]   wr_entry;
    logic [IDXW-1:0] rd_addr;
    logic [EW-1:0]   rd_entry;
    logic            is_full;
    logic            is_dup;
    logic            store;

    assign wr_entry = {flags, result};
    assign is_full  = (count_q == DEPTH_C);
    // Age 0 is the slot just behind the write pointer; wraps naturally in IDXW bits.
    assign rd_addr  = wr_ptr_q - IDXW'(1) - view_q;
    assign rd_entry = mem_q[rd_addr];

`ifdef RESULT_HISTORY_DEDUP_EN
    logic [IDXW-1:0] newest_addr;
    assign newest_addr = wr_ptr_q - IDXW'(1);
    assign is_dup      = (count_q != '0) && (mem_q[newest_addr] == wr_entry);
`else
    assign is_dup      = 1'b0;
`endif

    // A coincident clear drops the capture entirely.
    assign store = capture && !clear && !is_dup;

    // Next-state: clear beats capture, capture beats stepping.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        view_d   = view_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            view_d   = '0;
            ovf_d    = 1'b0;
        end else if (capture) begin
            view_d = '0;
            if (!is_dup) begin
                wr_ptr_d = wr_ptr_q + IDXW'(1);
                if (is_full) ovf_d   = 1'b1;
                else         count_d = count_q + (IDXW+1)'(1);
            end
        end else if (step_old && !step_new) begin
            // Saturate at the oldest valid entry (view < count-1).
            if (({1'b0, view_q} + (IDXW+1)'(1)) < count_q)
                view_d = view_q + IDXW'(1);
        end else if (step_new && !step_old) begin
            if (view_q != '0)
                view_d = view_q - IDXW'(1);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            view_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            view_q   <= view_d;
            ovf_q    <= ovf_d;
        end
    end

    // History storage write port.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: storage is deliberately not reset; count_q gates which entries are visible.
        if (store)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    // Display mux: live pass-through, blank when empty, else selected entry.
    always_comb begin
        disp_value = '0;
        disp_flags = '0;
        if (live) begin
            disp_value = result;
            disp_flags = flags;
        end else if (count_q != '0) begin
            {disp_flags, disp_value} = rd_entry;
        end
    end

    assign view_idx = view_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = is_full;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_result_history.sv
// Self-checking bench for result_history: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_result_history;

    localparam int DEPTH = 8;
    localparam int IDXW  = 3;

    logic            CLOCK_50 = 1'b0;
    logic            rst_n;
    logic            capture, clear, live, step_old, step_new;
    logic [15:0]     result;
    logic [4:0]      flags;
    logic [15:0]     disp_value;
    logic [4:0]      disp_flags;
    logic [IDXW-1:0] view_idx;
    logic [IDXW:0]   count;
    logic            empty, full, overflow;

    int vectors     = 0;
    int miscompares = 0;

    result_history #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .capture    (capture),
        .clear      (clear),
        .result     (result),
        .flags      (flags),
        .live       (live),
        .step_old   (step_old),
        .step_new   (step_new),
        .disp_value (disp_value),
        .disp_flags (disp_flags),
        .view_idx   (view_idx),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- reference model: newest entry at index 0 ----------------
    logic [20:0] hist[$];
    int          m_view;
    bit          m_ovf;

    task automatic model_reset();
        hist.delete();
        m_view = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        bit dup;
        dup = 1'b0;
`ifdef RESULT_HISTORY_DEDUP_EN
        if (hist.size() > 0 && hist[0] == {flags, result}) dup = 1'b1;
`endif
        if (clear) begin
            model_reset();
        end else if (capture) begin
            m_view = 0;
            if (!dup) begin
                hist.push_front({flags, result});
                if (hist.size() > DEPTH) begin
                    void'(hist.pop_back());
                    m_ovf = 1'b1;
                end
            end
        end else if (step_old && !step_new) begin
            if (m_view + 1 < hist.size()) m_view++;
        end else if (step_new && !step_old) begin
            if (m_view > 0) m_view--;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        #1;
        capture  = 1'b0;
        clear    = 1'b0;
        step_old = 1'b0;
        step_new = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [20:0] e;
        if (live)                 e = {flags, result};
        else if (hist.size() == 0) e = '0;
        else                      e = hist[m_view];
        check({tag, ".value"},    32'(disp_value), 32'(e[15:0]));
        check({tag, ".flags"},    32'(disp_flags), 32'(e[20:16]));
        check({tag, ".view"},     32'(view_idx),   32'(m_view));
        check({tag, ".count"},    32'(count),      32'(hist.size()));
        check({tag, ".empty"},    32'(empty),      32'(hist.size() == 0));
        check({tag, ".full"},     32'(full),       32'(hist.size() == DEPTH));
        check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
    endtask

    task automatic do_capture(input logic [15:0] r, input logic [4:0] f);
        result  = r;
        flags   = f;
        capture = 1'b1;
        tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        cap, clr, sold, snew;
        logic [15:0] res;
        logic [4:0]  flg;
        logic [15:0] e_val;
        logic [4:0]  e_flg;
        logic [2:0]  e_view;
        logic [3:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic cap, input logic clr, input logic sold, input logic snew,
                                input logic [15:0] res, input logic [4:0] flg,
                                input logic [15:0] e_val, input logic [4:0] e_flg,
                                input logic [2:0] e_view, input logic [3:0] e_cnt);
        vec_t v;
        v.cap = cap; v.clr = clr; v.sold = sold; v.snew = snew;
        v.res = res; v.flg = flg;
        v.e_val = e_val; v.e_flg = e_flg; v.e_view = e_view; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        //            cap clr old new  res       flg     e_val     e_flg  view cnt
        tbl[0]  = mk(0,  0,  0,  0,  16'h0000, 5'h00, 16'h0000, 5'h00, 0, 0);
        tbl[1]  = mk(1,  0,  0,  0,  16'h1234, 5'h00, 16'h1234, 5'h00, 0, 1);
        tbl[2]  = mk(1,  0,  0,  0,  16'h0001, 5'h01, 16'h0001, 5'h01, 0, 2);
        tbl[3]  = mk(1,  0,  0,  0,  16'h0002, 5'h02, 16'h0002, 5'h02, 0, 3);
        tbl[4]  = mk(1,  0,  0,  0,  16'h0003, 5'h03, 16'h0003, 5'h03, 0, 4);
        tbl[5]  = mk(0,  0,  1,  0,  16'h0000, 5'h00, 16'h0002, 5'h02, 1, 4);
        tbl[6]  = mk(0,  0,  1,  0,  16'h0000, 5'h00, 16'h0001, 5'h01, 2, 4);
        tbl[7]  = mk(0,  0,  1,  0,  16'h0000, 5'h00, 16'h1234, 5'h00, 3, 4);
        tbl[8]  = mk(0,  0,  1,  0,  16'h0000, 5'h00, 16'h1234, 5'h00, 3, 4);
        tbl[9]  = mk(0,  0,  0,  1,  16'h0000, 5'h00, 16'h0001, 5'h01, 2, 4);
        tbl[10] = mk(0,  0,  0,  1,  16'h0000, 5'h00, 16'h0002, 5'h02, 1, 4);
        tbl[11] = mk(0,  0,  0,  1,  16'h0000, 5'h00, 16'h0003, 5'h03, 0, 4);
        tbl[12] = mk(0,  0,  0,  1,  16'h0000, 5'h00, 16'h0003, 5'h03, 0, 4);
        tbl[13] = mk(1,  0,  1,  0,  16'h00AA, 5'h10, 16'h00AA, 5'h10, 0, 5);
        tbl[14] = mk(0,  0,  1,  1,  16'h0000, 5'h00, 16'h00AA, 5'h10, 0, 5);
        tbl[15] = mk(0,  0,  1,  0,  16'h0000, 5'h00, 16'h0003, 5'h03, 1, 5);
        tbl[16] = mk(0,  0,  1,  1,  16'h0000, 5'h00, 16'h0003, 5'h03, 1, 5);
        tbl[17] = mk(1,  1,  0,  0,  16'h00BB, 5'h1F, 16'h0000, 5'h00, 0, 0);

        rst_n = 1'b0; capture = 0; clear = 0; live = 0; step_old = 0; step_new = 0;
        result = '0; flags = '0;
        model_reset();

        // Reset state, observed before any clock edge.
        #2;
        check("rst.value", 32'(disp_value), 32'h0);
        check("rst.count", 32'(count), 32'h0);
        check("rst.empty", 32'(empty), 32'h1);
        check("rst.view",  32'(view_idx), 32'h0);
        check("rst.ovf",   32'(overflow), 32'h0);
        #10 rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            capture  = tbl[i].cap;
            clear    = tbl[i].clr;
            step_old = tbl[i].sold;
            step_new = tbl[i].snew;
            result   = tbl[i].res;
            flags    = tbl[i].flg;
            tick();
            check($sformatf("tbl%0d.value", i), 32'(disp_value), 32'(tbl[i].e_val));
            check($sformatf("tbl%0d.flags", i), 32'(disp_flags), 32'(tbl[i].e_flg));
            check($sformatf("tbl%0d.view",  i), 32'(view_idx),   32'(tbl[i].e_view));
            check($sformatf("tbl%0d.count", i), 32'(count),      32'(tbl[i].e_cnt));
        end

        // Wrap-around: ten captures into an 8-deep buffer.
        for (int v = 16'h0010; v <= 16'h0019; v++) do_capture(16'(v), 5'h00);
        check("wrap.count", 32'(count), 32'd8);
        check("wrap.full",  32'(full), 32'h1);
        check("wrap.ovf",   32'(overflow), 32'h1);
        check("wrap.newest", 32'(disp_value), 32'h0019);
        for (int s = 0; s < 7; s++) begin
            step_old = 1'b1;
            tick();
        end
        check("wrap.oldest", 32'(disp_value), 32'h0012);
        check("wrap.view7",  32'(view_idx), 32'd7);
        step_old = 1'b1;
        tick();
        check("wrap.sat", 32'(view_idx), 32'd7);

        // Live pass-through leaves buffer state alone.
        live = 1'b1; result = 16'hBEEF; flags = 5'b10000;
        tick();
        check("live.value", 32'(disp_value), 32'hBEEF);
        check("live.flags", 32'(disp_flags), 32'h10);
        check("live.count", 32'(count), 32'd8);
        live = 1'b0;

        // Asynchronous reset mid-operation, away from any clock edge.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("areset.count", 32'(count), 32'h0);
        check("areset.ovf",   32'(overflow), 32'h0);
        check("areset.view",  32'(view_idx), 32'h0);
        check("areset.value", 32'(disp_value), 32'h0);
        #1 rst_n = 1'b1;
        do_capture(16'h0077, 5'h07);
        check("post.value", 32'(disp_value), 32'h0077);
        check("post.flags", 32'(disp_flags), 32'h07);
        check("post.count", 32'(count), 32'd1);

        // Duplicate captures.
        clear = 1'b1;
        tick();
        do_capture(16'h0042, 5'h00);
        do_capture(16'h0042, 5'h00);
        do_capture(16'h0043, 5'h00);
`ifdef RESULT_HISTORY_DEDUP_EN
        check("dedup.count", 32'(count), 32'd2);
`else
        check("dedup.count", 32'(count), 32'd3);
`endif
        step_old = 1'b1;
        tick();
        check("dedup.older", 32'(disp_value), 32'h0042);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            clear    = ($urandom_range(0, 99) < 3);
            capture  = ($urandom_range(0, 99) < 35);
            step_old = ($urandom_range(0, 99) < 35);
            step_new = ($urandom_range(0, 99) < 30);
            live     = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 3) == 0 && hist.size() > 0) begin
                {flags, result} = hist[0];
            end else begin
                result = 16'($urandom);
                flags  = 5'($urandom);
            end
            tick();
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
